adder_share_arb: RTL and testbench

Shares one pipelined ripple adder (`pipeliningadder`: a, b, ci in; s, co out; fixed latency) between NREQ requesters.
- Picks one requester per cycle by round-robin and drives its operands into the adder.
- Tracks the issuing requester through a tag pipeline matched to the adder latency.
- Returns each sum to the requester that issued it.
- Provides a flush/drain sequence so software or sequencers can quiesce the adder.

---
 rtl/adder_share_arb_pkg.sv | 44 ++++
 rtl/adder_share_arb_rr_arb_core.sv | 42 ++++
 rtl/adder_share_arb.sv | 211 +++++++++++++++++++++
 tb/tb_adder_share_arb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_arb_pkg.sv
// -----------------------------------------------------------------------------
// adder_share_arb_pkg
// Shared types, constants and helpers for the adder-sharing arbiter.
//   arb_state_e : flush/drain FSM states (RUN, DRAIN, HALT)
//   CNT_W       : width of each per-requester grant statistics counter
//   MAX_REQ     : upper bound on requesters the priority search supports
//   rr_search   : rotate-priority search, returns the first set request
//                 at or above ptr (wrapping), or -1 when none is set
// -----------------------------------------------------------------------------
package adder_share_arb_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } arb_state_e;

    localparam int CNT_W   = 16;
    localparam int MAX_REQ = 32;
    localparam int MAX_IW  = 5;

    // Walk the candidates from highest rotation offset down to zero so the
    // lowest offset (closest to ptr) is the one left in sel.
    function automatic int rr_search(input logic [MAX_REQ-1:0] req,
                                     input int                 nreq,
                                     input int                 ptr);
        int sel;
        int idx;
        sel = -1;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < nreq) begin
                idx = ptr + k;
                if (idx >= nreq) begin
                    idx = idx - nreq;
                end
                if (req[idx[MAX_IW-1:0]]) begin
                    sel = idx;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/adder_share_arb_rr_arb_core.sv
// -----------------------------------------------------------------------------
// rr_arb_core
// Purely combinational round-robin grant selection.
//   req_valid : per-requester pending operation
//   ptr       : requester with highest priority this cycle
//   en        : grants allowed this cycle
//   grant     : one-hot grant (all zero when nothing is granted)
//   grant_idx : index of the granted requester (0 when none)
//   grant_any : a grant was issued
// -----------------------------------------------------------------------------
module rr_arb_core
    import adder_share_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_any
);

    logic [MAX_REQ-1:0] w_req_ext;
    int                 w_sel;

    always_comb begin
        w_req_ext            = '0;
        w_req_ext[NREQ-1:0]  = req_valid;
        w_sel                = rr_search(w_req_ext, NREQ, int'(ptr));
        grant                = '0;
        grant_idx            = '0;
        grant_any            = 1'b0;
        if (en && (w_sel >= 0)) begin
            grant_any        = 1'b1;
            grant_idx        = IW'(w_sel);
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// -----------------------------------------------------------------------------
// adder_share_arb
// Shares one external pipelined adder between NREQ requesters. One requester
// is granted per cycle (round-robin), its operands are muxed onto the adder,
// and a tag pipeline matched to the adder latency routes each sum back to the
// requester that issued it. flush_req stops granting and drains in-flight ops;
// flush_done reports the halted, empty state.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (req_ready one-hot)
//   req_a/req_b/req_ci  : packed operands, requester i at [i*W +: W]
//   add_a/add_b/add_ci  : operands to the adder (0 when nothing granted)
//   add_s/add_co        : adder result, LATENCY cycles after issue
//   rsp_valid           : one-hot owner of the current result
//   rsp_s/rsp_co        : result, shared by all requesters
//   flush_req           : level, stop granting and drain
//   flush_done          : halted with nothing in flight
//   stat_clr, grant_cnt : only with ADDER_SHARE_ARB_STATS_EN; saturating
//                         per-requester handshake counters, cleared by a
//                         handshake taken while stat_clr is high
//
// Optional feature macro: ADDER_SHARE_ARB_STATS_EN
// -----------------------------------------------------------------------------
module adder_share_arb
    import adder_share_arb_pkg::*;
#(
    parameter int W       = 4,
    parameter int NREQ    = 4,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*W-1:0]  req_a,
    input  logic [NREQ*W-1:0]  req_b,
    input  logic [NREQ-1:0]    req_ci,
    output logic [W-1:0]       add_a,
    output logic [W-1:0]       add_b,
    output logic               add_ci,
    input  logic [W-1:0]       add_s,
    input  logic               add_co,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [W-1:0]       rsp_s,
    output logic               rsp_co,
`ifdef ADDER_SHARE_ARB_STATS_EN
    input  logic               stat_clr,
    output logic [NREQ*CNT_W-1:0] grant_cnt,
`endif
    input  logic               flush_req,
    output logic               flush_done
);

    localparam int IW = $clog2(NREQ);

    arb_state_e       r_state;
    logic             r_flush_done;
    logic [IW-1:0]    r_ptr;
    logic             r_tag_vld_p [LATENCY];
    logic [IW-1:0]    r_tag_idx_p [LATENCY];

    logic             w_en;
    logic [NREQ-1:0]  w_grant;
    logic [IW-1:0]    w_grant_idx;
    logic             w_grant_any;
    logic             w_busy;

    // Grants only while running and not being asked to flush; reset also
    // blocks them so no handshake is reported in a cycle that gets discarded.
    assign w_en = !rst && (r_state == RUN) && !flush_req;

    rr_arb_core #(
        .NREQ (NREQ)
    ) u_rr_arb_core (
        .req_valid (req_valid),
        .ptr       (r_ptr),
        .en        (w_en),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_any (w_grant_any)
    );

    assign req_ready  = w_grant;
    assign flush_done = r_flush_done;

    // Operand mux: one-hot select, all zero without a grant
    always_comb begin
        add_a  = '0;
        add_b  = '0;
        add_ci = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                add_a  = req_a[i*W +: W];
                add_b  = req_b[i*W +: W];
                add_ci = req_ci[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant_any) begin
            r_ptr <= (w_grant_idx == IW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
        end
    end

    // Stage boundary p0..p(LATENCY-1): tag valid (reset) travels with idx (no reset)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LATENCY; s++) begin
                r_tag_vld_p[s] <= 1'b0;
            end
        end else begin
            r_tag_vld_p[0] <= w_grant_any;
            for (int s = 1; s < LATENCY; s++) begin
                r_tag_vld_p[s] <= r_tag_vld_p[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_tag_idx_p[0] <= w_grant_idx;
        for (int s = 1; s < LATENCY; s++) begin
            r_tag_idx_p[s] <= r_tag_idx_p[s-1];
        end
    end

    // Something will still be in flight after this edge. The final stage is
    // retiring now, so it does not count; this lets HALT (and flush_done)
    // follow the last response by exactly one cycle.
    always_comb begin
        w_busy = w_grant_any;
        for (int s = 0; s < LATENCY - 1; s++) begin
            w_busy = w_busy | r_tag_vld_p[s];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_flush_done <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (flush_req) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!w_busy) begin
                        r_state      <= HALT;
                        r_flush_done <= 1'b1;
                    end
                end
                HALT: begin
                    if (!flush_req) begin
                        r_state      <= RUN;
                        r_flush_done <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= RUN;
                    r_flush_done <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = r_tag_vld_p[LATENCY-1] && (r_tag_idx_p[LATENCY-1] == IW'(i));
        end
    end

    assign rsp_s  = add_s;
    assign rsp_co = add_co;

`ifdef ADDER_SHARE_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt [NREQ];

    // A grant always coincides with req_valid, so grant[i] is the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_grant[i]) begin
                    if (stat_clr) begin
                        r_cnt[i] <= '0;
                    end else if (r_cnt[i] != {CNT_W{1'b1}}) begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// -----------------------------------------------------------------------------
// tb_adder_share_arb
// Drives directed and random traffic into adder_share_arb with a behavioural
// LATENCY-stage adder attached. A reference model predicts grants, operands,
// flush_done and (optionally) grant counters each cycle and pushes the
// expected responses into a scoreboard queue; a separate monitor compares
// every cycle's rsp_valid/rsp_s/rsp_co against that queue.
// -----------------------------------------------------------------------------
module tb_adder_share_arb;

    localparam int W       = 4;
    localparam int NREQ    = 4;
    localparam int LATENCY = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*W-1:0]  req_a;
    logic [NREQ*W-1:0]  req_b;
    logic [NREQ-1:0]    req_ci;
    logic [W-1:0]       add_a;
    logic [W-1:0]       add_b;
    logic               add_ci;
    logic [W-1:0]       add_s;
    logic               add_co;
    logic [NREQ-1:0]    rsp_valid;
    logic [W-1:0]       rsp_s;
    logic               rsp_co;
    logic               flush_req;
    logic               flush_done;
`ifdef ADDER_SHARE_ARB_STATS_EN
    logic               stat_clr;
    logic [NREQ*16-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    adder_share_arb #(
        .W       (W),
        .NREQ    (NREQ),
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ci     (req_ci),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_ci     (add_ci),
        .add_s      (add_s),
        .add_co     (add_co),
        .rsp_valid  (rsp_valid),
        .rsp_s      (rsp_s),
        .rsp_co     (rsp_co),
`ifdef ADDER_SHARE_ARB_STATS_EN
        .stat_clr   (stat_clr),
        .grant_cnt  (grant_cnt),
`endif
        .flush_req  (flush_req),
        .flush_done (flush_done)
    );

    // Behavioural pipelined adder: {co,s} = a+b+ci, LATENCY cycles later
    logic [W:0] add_pipe [LATENCY];
    always @(posedge clk) begin
        add_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_ci};
        for (int s = 1; s < LATENCY; s++) begin
            add_pipe[s] <= add_pipe[s-1];
        end
    end
    assign {add_co, add_s} = add_pipe[LATENCY-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         idx;
        logic [W-1:0] s;
        logic       co;
        int         due;
    } exp_t;
    exp_t sbq[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model state
    typedef enum int {M_RUN, M_DRAIN, M_HALT} mstate_t;
    mstate_t m_state      = M_RUN;
    int      m_ptr        = 0;
    int      m_last_issue = -1000;
`ifdef ADDER_SHARE_ARB_STATS_EN
    logic [15:0] m_cnt [NREQ];
    initial for (int i = 0; i < NREQ; i++) m_cnt[i] = '0;
`endif

    // One clock cycle: drive inputs, check combinational/registered outputs
    // against the model, record the expected response, advance the model.
    task automatic step(input logic [NREQ-1:0]   v,
                        input logic [NREQ*W-1:0] a,
                        input logic [NREQ*W-1:0] b,
                        input logic [NREQ-1:0]   ci,
                        input logic              fl,
                        input logic              rs,
                        input logic              sc);
        int              g;
        logic [NREQ-1:0] exp_rdy;
        logic [W-1:0]    ea;
        logic [W-1:0]    eb;
        logic            eci;
        logic [W:0]      sum;
        bit              pend;
        @(posedge clk);
        #1;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        req_ci    = ci;
        flush_req = fl;
        rst       = rs;
`ifdef ADDER_SHARE_ARB_STATS_EN
        stat_clr  = sc;
`endif
        #1;
        g = -1;
        if (!rs && m_state == M_RUN && !fl) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        exp_rdy = '0;
        ea      = '0;
        eb      = '0;
        eci     = 1'b0;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            ea         = a[g*W +: W];
            eb         = b[g*W +: W];
            eci        = ci[g];
        end
        chk("req_ready",  64'(req_ready),  64'(exp_rdy));
        chk("add_a",      64'(add_a),      64'(ea));
        chk("add_b",      64'(add_b),      64'(eb));
        chk("add_ci",     64'(add_ci),     64'(eci));
        chk("flush_done", 64'(flush_done), 64'(m_state == M_HALT));
`ifdef ADDER_SHARE_ARB_STATS_EN
        begin
            logic [NREQ*16-1:0] ecnt;
            for (int i = 0; i < NREQ; i++) ecnt[i*16 +: 16] = m_cnt[i];
            chk("grant_cnt", 64'(grant_cnt), 64'(ecnt));
        end
`endif
        if (g >= 0) begin
            sum = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, eci};
            sbq.push_back('{g, sum[W-1:0], sum[W], cyc + LATENCY});
            m_ptr        = (g + 1) % NREQ;
            m_last_issue = cyc;
`ifdef ADDER_SHARE_ARB_STATS_EN
            if (sc) m_cnt[g] = '0;
            else if (m_cnt[g] != 16'hFFFF) m_cnt[g] = m_cnt[g] + 16'd1;
`endif
        end
        if (rs) begin
            m_state      = M_RUN;
            m_ptr        = 0;
            m_last_issue = -1000;
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].due > cyc) sbq.delete(i);
            end
`ifdef ADDER_SHARE_ARB_STATS_EN
            for (int i = 0; i < NREQ; i++) m_cnt[i] = '0;
`endif
        end else begin
            pend = (m_last_issue + LATENCY > cyc);
            case (m_state)
                M_RUN:   if (fl)    m_state = M_DRAIN;
                M_DRAIN: if (!pend) m_state = M_HALT;
                M_HALT:  if (!fl)   m_state = M_RUN;
                default: m_state = M_RUN;
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compares every cycle's response against the scoreboard head
    initial begin
        logic [NREQ-1:0] exp_v;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_v = '0;
            if (sbq.size() > 0 && sbq[0].due == cyc) exp_v[sbq[0].idx] = 1'b1;
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                chk("rsp_s",  64'(rsp_s),  64'(sbq[0].s));
                chk("rsp_co", 64'(rsp_co), 64'(sbq[0].co));
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] r0;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        fl_r;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_ci    = '0;
        flush_req = 1'b0;
`ifdef ADDER_SHARE_ARB_STATS_EN
        stat_clr  = 1'b0;
`endif
        repeat (3) step('0, '0, '0, '0, 1'b0, 1'b1, 1'b0);

        // Single requester 2: 0110+1101+1 -> co=1, s=0100
        repeat (8) step(4'b0100, {4{4'h6}}, {4{4'hD}}, 4'b0100, 1'b0, 1'b0, 1'b0);

        // All requesters valid: 1111+1111+0 -> co=1, s=1110
        repeat (4) step(4'b1111, {4{4'hF}}, {4{4'hF}}, 4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (16) begin
            r0 = $urandom; r1 = $urandom; r2 = $urandom;
            step(4'b1111, r0[15:0], r1[15:0], r2[3:0], 1'b0, 1'b0, 1'b0);
        end

        // Sparse: grant 0 moves ptr to 1, then only 0 and 3 valid -> 3,0,3
        step(4'b0001, 16'h1234, 16'h5678, 4'b0001, 1'b0, 1'b0, 1'b0);
        repeat (3) step(4'b1001, 16'h9ABC, 16'hDEF0, 4'b1000, 1'b0, 1'b0, 1'b0);

        // Flush with two ops in flight, then release
        idle(3);
        repeat (2) step(4'b1111, 16'hA5C3, 16'h3C5A, 4'b0101, 1'b0, 1'b0, 1'b0);
        repeat (6) step(4'b1111, 16'hA5C3, 16'h3C5A, 4'b0101, 1'b1, 1'b0, 1'b0);
        repeat (3) step(4'b1111, 16'h1111, 16'h7777, 4'b1111, 1'b0, 1'b0, 1'b0);

        // Flush dropped while draining: DRAIN -> HALT -> RUN
        step(4'b1111, 16'h2468, 16'hFFFF, 4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'b1111, 16'h2468, 16'hFFFF, 4'b0000, 1'b1, 1'b0, 1'b0);
        repeat (5) step(4'b1111, 16'h2468, 16'hFFFF, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Reset one cycle after a handshake: that op never responds
        idle(3);
        step(4'b0010, 16'h00F0, 16'h00F0, 4'b0010, 1'b0, 1'b0, 1'b0);
        step('0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        idle(4);

        // Random traffic with occasional flushes and resets
        fl_r = 1'b0;
        repeat (400) begin
            r0 = $urandom; r1 = $urandom; r2 = $urandom;
            if (r2[31:28] == 4'h0) fl_r = ~fl_r;
            step(r2[3:0], r0[15:0], r1[15:0], r2[7:4], fl_r,
                 (r2[27:21] == 7'd0), 1'b0);
        end
        idle(4);

`ifdef ADDER_SHARE_ARB_STATS_EN
        // Saturate requester 1's counter, then clear it with a handshake
        repeat (70000) step(4'b0010, 16'h0010, 16'h0020, 4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'b0010, 16'h0010, 16'h0020, 4'b0000, 1'b0, 1'b0, 1'b1);
        idle(2);
`endif

        idle(LATENCY + 3);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
